sterownik_rejestru: RTL and testbench

Sequencing controller for the 4-bit bidirectional shift register (S1S0: 00 hold, 01 shift right toward LSB with MSB fill 0, 10 shift left toward MSB with LSB fill 0, 11 parallel load).
- Accepts one command at a time over a valid/ready handshake.
- Drives the register's S1/S0/I inputs for the required number of cycles.
- Returns the resulting register contents over a second valid/ready handshake.
- Sits between a host/bus FSM and the register instance; the controller and the register share CLK and RST.

---
 rtl/rejestr_pkg.sv | 29 ++
 rtl/licznik_przesuniec.sv | 28 ++
 rtl/rejestr_przesuwny.sv | 26 ++
 rtl/sterownik_rejestru.sv | 152 +++++++++++++++
 tb/tb_sterownik_rejestru.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/rejestr_pkg.sv
// rtl/rejestr_pkg.sv - shared types and constants for the shift-register sequencing controller
package rejestr_pkg;

  localparam int WIDTH = 4;
  localparam int AMT_W = 3;

  typedef enum logic [1:0] {
    OP_READ     = 2'b00,
    OP_SHR      = 2'b01,
    OP_SHL      = 2'b10,
    OP_LOAD_SHR = 2'b11
  } op_t;

  // Encoded directly as the register's {S1,S0} select.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/licznik_przesuniec.sv
// rtl/licznik_przesuniec.sv - loadable shift down-counter with a last-cycle flag
module licznik_przesuniec #(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [AMT_W-1:0] load_value,
  input  logic             dec,
  output logic             last
);

  logic [AMT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // High during the final shift cycle of a burst.
  assign last = (count == AMT_W'(1));

endmodule

// File: rtl/rejestr_przesuwny.sv
// rtl/rejestr_przesuwny.sv - 4-bit bidirectional shift register driven by the controller
module rejestr_przesuwny #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S1,
  input  logic             S0,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= '0;
    end else begin
      case ({S1, S0})
        2'b01:   Q <= Q >> 1;
        2'b10:   Q <= Q << 1;
        2'b11:   Q <= I;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/sterownik_rejestru.sv
// rtl/sterownik_rejestru.sv - command/result sequencer driving the shift register's S1/S0/I
module sterownik_rejestru #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [AMT_W-1:0] CMD_AMT,
  input  logic [WIDTH-1:0] CMD_DATA,
  output logic             S1,
  output logic             S0,
  output logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] Q,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic             BUSY
);

  import rejestr_pkg::*;

  state_t           state, state_nx;
  mode_t            mode_q, mode_nx;
  logic [WIDTH-1:0] i_q, i_nx;
  logic [AMT_W-1:0] amt_q, amt_nx;
  logic             res_valid_q, res_valid_nx;
  logic [WIDTH-1:0] res_data_q, res_data_nx;

  logic             cnt_load;
  logic             cnt_dec;
  logic [AMT_W-1:0] cnt_value;
  logic             cnt_last;

  licznik_przesuniec #(.AMT_W(AMT_W)) u_licznik (
    .clk        (CLK),
    .rst        (RST),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .last       (cnt_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      mode_q      <= MODE_HOLD;
      i_q         <= '0;
      amt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state       <= state_nx;
      mode_q      <= mode_nx;
      i_q         <= i_nx;
      amt_q       <= amt_nx;
      res_valid_q <= res_valid_nx;
      res_data_q  <= res_data_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    mode_nx      = mode_q;
    i_nx         = i_q;
    amt_nx       = amt_q;
    res_valid_nx = res_valid_q;
    res_data_nx  = res_data_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_value    = '0;

    case (state)
      IDLE: begin
        mode_nx = MODE_HOLD;
        i_nx    = '0;
        if (CMD_VALID) begin
          amt_nx = CMD_AMT;
          case (op_t'(CMD_OP))
            OP_LOAD_SHR: begin
              state_nx = LOAD;
              mode_nx  = MODE_LOAD;
              i_nx     = CMD_DATA;
            end
            OP_SHR, OP_SHL: begin
              if (CMD_AMT != '0) begin
                state_nx  = SHIFT;
                mode_nx   = (CMD_OP == OP_SHR) ? MODE_SHR : MODE_SHL;
                cnt_load  = 1'b1;
                cnt_value = CMD_AMT;
              end else begin
                state_nx = DONE;
              end
            end
            default: state_nx = DONE;
          endcase
        end
      end

      // The register captures I at the edge that leaves this state.
      LOAD: begin
        i_nx = '0;
        if (amt_q != '0) begin
          state_nx  = SHIFT;
          mode_nx   = MODE_SHR;
          cnt_load  = 1'b1;
          cnt_value = amt_q;
        end else begin
          state_nx = DONE;
          mode_nx  = MODE_HOLD;
        end
      end

      SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_nx = DONE;
          mode_nx  = MODE_HOLD;
        end
      end

      // Q has settled after the last mode edge, so it is sampled one edge into DONE.
      DONE: begin
        mode_nx = MODE_HOLD;
        i_nx    = '0;
        if (!res_valid_q) begin
          res_valid_nx = 1'b1;
          res_data_nx  = Q;
        end else if (RES_READY) begin
          res_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
        mode_nx  = MODE_HOLD;
        i_nx     = '0;
      end
    endcase
  end

  assign {S1, S0}  = mode_q;
  assign I         = i_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign CMD_READY = (state == IDLE);
  assign BUSY      = !CMD_READY;

endmodule

// File: tb/tb_sterownik_rejestru.sv
// tb/tb_sterownik_rejestru.sv - self-checking bench for the controller plus the real shift register
module tb_sterownik_rejestru;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [2:0] CMD_AMT;
  logic [3:0] CMD_DATA;
  logic       S1, S0;
  logic [3:0] I;
  logic [3:0] Q;
  logic       RES_VALID;
  logic       RES_READY;
  logic [3:0] RES_DATA;
  logic       BUSY;

  int checks = 0;
  int errors = 0;
  logic [3:0] reg_m;

  always #5 CLK = ~CLK;

  sterownik_rejestru #(.WIDTH(4), .AMT_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_AMT(CMD_AMT), .CMD_DATA(CMD_DATA),
    .S1(S1), .S0(S0), .I(I), .Q(Q),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .BUSY(BUSY)
  );

  rejestr_przesuwny #(.WIDTH(4)) u_rej (
    .CLK(CLK), .RST(RST), .S1(S1), .S0(S0), .I(I), .Q(Q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: register contents after a command, from the operation's meaning.
  function automatic logic [3:0] model_res(input logic [1:0] op, input int amt,
                                           input logic [3:0] data, input logic [3:0] cur);
    int v;
    case (op)
      2'b01:   v = int'(cur) >> amt;
      2'b10:   v = (int'(cur) << amt) % 16;
      2'b11:   v = int'(data) >> amt;
      default: v = int'(cur);
    endcase
    return 4'(v);
  endfunction

  function automatic int model_lat(input logic [1:0] op, input int amt);
    if (op == 2'b00) return 2;
    if (op == 2'b11) return amt + 3;
    return amt + 2;
  endfunction

  function automatic int model_act(input logic [1:0] op, input int amt);
    if (op == 2'b00) return 0;
    if (op == 2'b11) return amt + 1;
    return amt;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] amt, input logic [3:0] data,
                         input int hold, input int pulse_at,
                         output logic [3:0] res, output int lat, output int act);
    int guard;
    guard = 0;
    @(negedge CLK);
    while (!CMD_READY && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    check("cmd_ready_before", 32'(CMD_READY), 32'd1);
    CMD_OP = op; CMD_AMT = amt; CMD_DATA = data; CMD_VALID = 1'b1;
    @(posedge CLK);
    lat = 1; act = 0;
    @(negedge CLK);
    CMD_VALID = 1'b0; CMD_OP = 2'($urandom); CMD_AMT = 3'($urandom); CMD_DATA = 4'($urandom);
    check("busy_after_accept", 32'({CMD_READY, BUSY}), 32'b01);
    while (!RES_VALID && lat < 40) begin
      if ({S1, S0} != 2'b00) act++;
      if (lat == pulse_at) begin
        CMD_VALID = 1'b1; CMD_OP = 2'b00;
        check("ready_low_during_op", 32'(CMD_READY), 32'd0);
      end else begin
        CMD_VALID = 1'b0;
      end
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    CMD_VALID = 1'b0;
    check("res_valid_seen", 32'(RES_VALID), 32'd1);
    check("done_mode", 32'({S1, S0}), 32'd0);
    res = RES_DATA;
    repeat (hold) begin
      @(posedge CLK); @(negedge CLK);
      check("hold_valid", 32'(RES_VALID), 32'd1);
      check("hold_data", 32'(RES_DATA), 32'(res));
      check("hold_ready", 32'({CMD_READY, BUSY}), 32'b01);
      check("hold_mode", 32'({S1, S0}), 32'd0);
    end
    RES_READY = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RES_READY = 1'b0;
    check("consumed", 32'({RES_VALID, CMD_READY, BUSY}), 32'b010);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] amt;
    logic [3:0] data;
    logic [3:0] exp_data;
    int         exp_lat;
    int         exp_act;
    int         hold;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] res;
    int lat, act;

    vecs[0] = '{2'b11, 3'd0, 4'b1011, 4'b1011, 3,  1, 0};
    vecs[1] = '{2'b11, 3'd1, 4'b1011, 4'b0101, 4,  2, 0};
    vecs[2] = '{2'b10, 3'd1, 4'b1111, 4'b1010, 3,  1, 0};
    vecs[3] = '{2'b10, 3'd5, 4'b1111, 4'b0000, 7,  5, 4};
    vecs[4] = '{2'b11, 3'd0, 4'b0110, 4'b0110, 3,  1, 1};
    vecs[5] = '{2'b00, 3'd3, 4'b1001, 4'b0110, 2,  0, 0};
    vecs[6] = '{2'b01, 3'd0, 4'b1001, 4'b0110, 2,  0, 0};
    vecs[7] = '{2'b01, 3'd2, 4'b1001, 4'b0001, 4,  2, 0};
    vecs[8] = '{2'b11, 3'd7, 4'b1111, 4'b0000, 10, 8, 2};

    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_AMT = '0; CMD_DATA = '0; RES_READY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_ready_busy", 32'({CMD_READY, BUSY}), 32'b10);
    check("reset_res", 32'({RES_VALID, RES_DATA}), 32'd0);
    check("reset_mode_i", 32'({S1, S0, I}), 32'd0);
    check("reset_q", 32'(Q), 32'd0);
    RST = 1'b0;
    reg_m = 4'd0;

    for (int k = 0; k < 9; k++) begin
      run_cmd(vecs[k].op, vecs[k].amt, vecs[k].data, vecs[k].hold, -1, res, lat, act);
      check($sformatf("vec%0d_data", k), 32'(res), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
      check($sformatf("vec%0d_mode_cycles", k), 32'(act), 32'(vecs[k].exp_act));
      reg_m = vecs[k].exp_data;
    end

    // A command pulse while shifting must not be taken.
    run_cmd(2'b11, 3'd0, 4'b1111, 0, -1, res, lat, act);
    run_cmd(2'b10, 3'd3, 4'b0000, 0, 2, res, lat, act);
    check("pulse_data", 32'(res), 32'b1000);
    check("pulse_latency", 32'(lat), 32'd5);
    repeat (3) begin
      @(posedge CLK); @(negedge CLK);
      check("pulse_not_taken", 32'({CMD_READY, BUSY, RES_VALID}), 32'b100);
    end

    // Reset in the second shift cycle of SHR 6.
    run_cmd(2'b11, 3'd0, 4'b1111, 0, -1, res, lat, act);
    @(negedge CLK);
    CMD_OP = 2'b01; CMD_AMT = 3'd6; CMD_VALID = 1'b1;
    @(posedge CLK); @(negedge CLK);
    CMD_VALID = 1'b0;
    check("rst_seq_shift1", 32'({S1, S0}), 32'b01);
    @(posedge CLK); @(negedge CLK);
    check("rst_seq_shift2", 32'({S1, S0}), 32'b01);
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0;
    check("rst_seq_ready", 32'({CMD_READY, BUSY}), 32'b10);
    check("rst_seq_res_valid", 32'(RES_VALID), 32'd0);
    check("rst_seq_mode", 32'({S1, S0}), 32'd0);
    check("rst_seq_q", 32'(Q), 32'd0);
    reg_m = 4'd0;

    for (int n = 0; n < 60; n++) begin
      logic [1:0] op;
      logic [2:0] amt;
      logic [3:0] data;
      logic [3:0] exp;
      op   = 2'($urandom_range(0, 3));
      amt  = 3'($urandom_range(0, 7));
      data = 4'($urandom);
      exp  = model_res(op, int'(amt), data, reg_m);
      run_cmd(op, amt, data, $urandom_range(0, 2), -1, res, lat, act);
      check($sformatf("rnd%0d_data", n), 32'(res), 32'(exp));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(model_lat(op, int'(amt))));
      check($sformatf("rnd%0d_mode_cycles", n), 32'(act), 32'(model_act(op, int'(amt))));
      reg_m = exp;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
